vga_timing_gen: RTL

- Parametrised VGA raster timing generator, successor to the fixed 640x480 timing embedded in the current tt_um top.
- Produces hsync, vsync, data-enable, pixel coordinates, line/frame strobes and a frame counter for downstream sprite and colour logic.
- Generalised in resolution, porches, sync polarity and pixel-clock division.
- Adds an ena-gated hold and a free-running frame counter.
- Sits between the tile clock and the uo_out colour/sync mux.

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, data-enable, coordinates, strobes and frame count.
// Define VGA_TEST_PATTERN_EN to drive an 8-bar colour test pattern on rrggbb; otherwise rrggbb is 0.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 1,
  parameter int FRAME_W  = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [5:0]         rrggbb
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SS   = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] H_SE   = XW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SS   = YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] V_SE   = YW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic HP = (H_POL != 0);
  localparam logic VP = (V_POL != 0);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      CLK_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: porch, sync, active and CLK_DIV parameters must all be >= 1");
  end

  logic [PW-1:0]      prescaler;
  logic [XW-1:0]      h_cnt;
  logic [YW-1:0]      v_cnt;
  logic [FRAME_W-1:0] frame_acc;

  logic tick;
  logic h_last;
  logic v_last;
  logic de_nx;
  logic hs_nx;
  logic vs_nx;

  always_comb begin
    tick   = ena && (prescaler == PRE_LAST);
    h_last = (h_cnt == H_LAST);
    v_last = (v_cnt == V_LAST);
    de_nx  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_nx  = ((h_cnt >= H_SS) && (h_cnt < H_SE)) ? HP : ~HP;
    vs_nx  = ((v_cnt >= V_SS) && (v_cnt < V_SE)) ? VP : ~VP;
  end

  // Outputs are registered from the position before it advances, so the
  // first tick after reset presents (0,0) with both strobes set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler   <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_acc   <= '0;
      hsync       <= ~HP;
      vsync       <= ~VP;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ena) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
      end
      if (tick) begin
        hsync       <= hs_nx;
        vsync       <= vs_nx;
        de          <= de_nx;
        x           <= h_cnt;
        y           <= v_cnt;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        frame_cnt   <= frame_acc;
        if (h_last) begin
          h_cnt <= '0;
          if (v_last) begin
            v_cnt     <= '0;
            frame_acc <= frame_acc + 1'b1;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;

  // Bar index counts how many fixed bar boundaries lie at or left of h_cnt.
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= XW'(k * (H_ACTIVE / 8))) begin
        bar = bar + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrggbb <= '0;
    end else if (tick) begin
      rrggbb <= de_nx ? {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]} : 6'b0;
    end
  end
`else
  assign rrggbb = 6'b0;
`endif

endmodule
